// File: rtl/fpga_cmd_pkg.sv
// Shared command, major-mode and sequencer-state definitions for the FPGA
// command path.
package fpga_cmd_pkg;

   localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
   localparam logic [3:0] CMD_SET_DIVISOR = 4'b0010;

   typedef enum logic [2:0] {
      MODE_LF_READ    = 3'b000,
      MODE_LF_EDGE    = 3'b001,
      MODE_HF_READER  = 3'b010,
      MODE_HF_SIM     = 3'b011,
      MODE_HF_ISO14A  = 3'b100,
      MODE_HF_SNOOP   = 3'b101,
      MODE_HF_TRACE   = 3'b110,
      MODE_OFF        = 3'b111
   } majorMode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_QUIESCE,
      ST_APPLY
   } seqState_t;

endpackage

// File: rtl/spi_cmd_rx.sv
// SPI slave front end: synchronises spck/ncs/mosi into ck_1356meg, assembles
// one frame per chip-select window and flags whether it had the right length.
module spi_cmd_rx #(
   parameter int CMD_BITS = 16
) (
   input  logic        ck_1356meg,
   input  logic        nreset,
   input  logic        spck,
   input  logic        mosi,
   input  logic        ncs,
   output logic        frame_valid,
   output logic        frame_bad,
   output logic [15:0] frame
);

   localparam int CW = $clog2(CMD_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(CMD_BITS);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CMD_BITS + 1);

   logic [1:0]    r_spckSync;
   logic [1:0]    r_ncsSync;
   logic [1:0]    r_mosiSync;
   logic          r_spckPrev;
   logic          r_ncsPrev;
   logic [15:0]   r_shift;
   logic [CW-1:0] r_bitCnt;

   logic w_spckRise;
   logic w_ncsRise;
   logic w_ncsFall;

   assign w_spckRise = r_spckSync[1] & ~r_spckPrev;
   assign w_ncsRise  = r_ncsSync[1] & ~r_ncsPrev;
   assign w_ncsFall  = ~r_ncsSync[1] & r_ncsPrev;

   // ncs synchronisers reset to the idle-high level so reset release never
   // looks like the end of a frame.
   always_ff @(posedge ck_1356meg or negedge nreset) begin
      if (!nreset) begin
         r_spckSync <= 2'b00;
         r_ncsSync  <= 2'b11;
         r_mosiSync <= 2'b00;
         r_spckPrev <= 1'b0;
         r_ncsPrev  <= 1'b1;
         r_shift    <= '0;
         r_bitCnt   <= '0;
      end else begin
         r_spckSync <= {r_spckSync[0], spck};
         r_ncsSync  <= {r_ncsSync[0], ncs};
         r_mosiSync <= {r_mosiSync[0], mosi};
         r_spckPrev <= r_spckSync[1];
         r_ncsPrev  <= r_ncsSync[1];
         if (w_ncsFall) begin
            r_bitCnt <= '0;
         end else if (!r_ncsSync[1] && w_spckRise) begin
            r_shift <= {r_shift[14:0], r_mosiSync[1]};
            if (r_bitCnt != CNT_MAX) r_bitCnt <= r_bitCnt + 1'b1;
         end
      end
   end

   assign frame_valid = w_ncsRise & (r_bitCnt == CNT_FULL);
   assign frame_bad   = w_ncsRise & (r_bitCnt != CNT_FULL);
   assign frame       = r_shift;

endmodule

// File: rtl/hf_mode_sequencer.sv
// ARM command decoder and glitch-free major-mode sequencer: every mode change
// parks the output muxes in OFF_MODE for a guard interval before handing over.
module hf_mode_sequencer
   import fpga_cmd_pkg::*;
#(
   parameter int         GUARD_CYCLES = 64,
   parameter int         CMD_BITS     = 16,
   parameter logic [2:0] OFF_MODE     = MODE_OFF
) (
   input  logic       ck_1356meg,
   input  logic       nreset,
   input  logic       spck,
   input  logic       mosi,
   input  logic       ncs,
   output logic [2:0] major_mode,
   output logic [4:0] conf_sub,
   output logic [7:0] divisor,
   output logic       switching,
   output logic       cmd_err
);

   localparam int GW = $clog2(GUARD_CYCLES);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

   logic        w_frameValid;
   logic        w_frameBad;
   logic [15:0] w_frame;
   logic [3:0]  w_opcode;
   logic [7:0]  w_payload;
   logic        w_isConf;
   logic        w_isDiv;
   logic        w_isErr;
   logic        w_unusedBits;

   seqState_t   r_state;
   logic [7:0]  r_pend;
   logic [GW-1:0] r_guardCnt;

   spi_cmd_rx #(
      .CMD_BITS (CMD_BITS)
   ) u_rx (
      .ck_1356meg  (ck_1356meg),
      .nreset      (nreset),
      .spck        (spck),
      .mosi        (mosi),
      .ncs         (ncs),
      .frame_valid (w_frameValid),
      .frame_bad   (w_frameBad),
      .frame       (w_frame)
   );

   assign w_opcode     = w_frame[15:12];
   assign w_payload    = w_frame[7:0];
   assign w_unusedBits = ^w_frame[11:8];
   assign w_isConf     = w_frameValid & (w_opcode == CMD_SET_CONFREG);
   assign w_isDiv      = w_frameValid & (w_opcode == CMD_SET_DIVISOR);
   assign w_isErr      = w_frameBad | (w_frameValid & ~w_isConf & ~w_isDiv);

   // A CONFREG seen while switching (including the APPLY cycle) restarts the
   // guard with the newest target, so outputs never leave OFF in between.
   always_ff @(posedge ck_1356meg or negedge nreset) begin
      if (!nreset) begin
         r_state    <= ST_IDLE;
         r_pend     <= '0;
         r_guardCnt <= '0;
         major_mode <= OFF_MODE;
         conf_sub   <= '0;
         divisor    <= '0;
         switching  <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         cmd_err <= w_isErr;
         if (w_isDiv) divisor <= w_payload;
         case (r_state)
            ST_IDLE: begin
               if (w_isConf) begin
                  if (w_payload[7:5] == major_mode) begin
                     conf_sub <= w_payload[4:0];
                  end else begin
                     r_pend     <= w_payload;
                     major_mode <= OFF_MODE;
                     r_guardCnt <= GUARD_LOAD;
                     switching  <= 1'b1;
                     r_state    <= ST_QUIESCE;
                  end
               end
            end
            ST_QUIESCE: begin
               if (w_isConf) begin
                  r_pend     <= w_payload;
                  r_guardCnt <= GUARD_LOAD;
               end else if (r_guardCnt == '0) begin
                  r_state <= ST_APPLY;
               end else begin
                  r_guardCnt <= r_guardCnt - 1'b1;
               end
            end
            ST_APPLY: begin
               if (w_isConf) begin
                  r_pend     <= w_payload;
                  r_guardCnt <= GUARD_LOAD;
                  r_state    <= ST_QUIESCE;
               end else begin
                  major_mode <= r_pend[7:5];
                  conf_sub   <= r_pend[4:0];
                  switching  <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// Self-checking bench: directed scenarios plus random SPI traffic, compared
// every cycle against an event-level model of the command rules.
module tb_hf_mode_sequencer;

   // Longer guard than the default so a second frame can land mid-guard.
   localparam int GUARD = 100;

   logic       ck_1356meg;
   logic       nreset;
   logic       spck;
   logic       mosi;
   logic       ncs;
   logic [2:0] major_mode;
   logic [4:0] conf_sub;
   logic [7:0] divisor;
   logic       switching;
   logic       cmd_err;

   hf_mode_sequencer #(
      .GUARD_CYCLES (GUARD),
      .CMD_BITS     (16),
      .OFF_MODE     (3'b111)
   ) dut (
      .ck_1356meg (ck_1356meg),
      .nreset     (nreset),
      .spck       (spck),
      .mosi       (mosi),
      .ncs        (ncs),
      .major_mode (major_mode),
      .conf_sub   (conf_sub),
      .divisor    (divisor),
      .switching  (switching),
      .cmd_err    (cmd_err)
   );

   typedef struct {
      int          at;
      logic [15:0] val;
      int          nbits;
   } frame_t;

   frame_t fq[$];
   int     cyc = 0;
   int     compared = 0;
   int     mismatched = 0;
   bit     checkEn = 0;
   int     errSeen = 0;
   bit     sawMode3 = 0;
   bit     sawSwitch = 0;
   int     lastRaise = 0;

   logic [2:0] mMode;
   logic [4:0] mSub;
   logic [7:0] mDiv;
   logic       mErr;
   logic       mSwitch;
   logic [7:0] mPend;
   int         mEnd;

   initial ck_1356meg = 1'b0;
   always #5 ck_1356meg = ~ck_1356meg;

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ck_1356meg);
      #1;
   endtask

   task automatic modelReset();
      mMode = 3'b111; mSub = '0; mDiv = '0; mErr = 1'b0;
      mSwitch = 1'b0; mPend = '0; mEnd = 0;
      fq.delete();
   endtask

   // Shift one frame MSB first at spck = ck/4, then release ncs; the frame's
   // effect is due three clock edges after the ncs rise (2-flop sync + decode).
   task automatic applyStimulus(input logic [15:0] value, input int nbits);
      tick(1);
      ncs = 1'b0;
      tick(3);
      for (int i = 0; i < nbits; i++) begin
         mosi = value[15 - (i % 16)];
         tick(2);
         spck = 1'b1;
         tick(2);
         spck = 1'b0;
      end
      tick(2);
      ncs = 1'b1;
      lastRaise = cyc;
      fq.push_back('{cyc + 3, value, nbits});
      tick(2);
   endtask

   // Reference model: each frame takes effect on its due edge; a mode change
   // completes GUARD+1 edges after it is accepted, later CONFREGs restart it.
   always @(posedge ck_1356meg) begin : modelProc
      frame_t     f;
      logic [7:0] nv;
      cyc++;
      if (nreset) begin
         mErr = 1'b0;
         if (fq.size() > 0 && fq[0].at == cyc) begin
            f  = fq.pop_front();
            nv = f.val[7:0];
            if (f.nbits != 16) begin
               mErr = 1'b1;
            end else if (f.val[15:12] == 4'd2) begin
               mDiv = nv;
            end else if (f.val[15:12] == 4'd1) begin
               if (mSwitch) begin
                  mPend = nv;
                  mEnd  = cyc + GUARD + 1;
               end else if (nv[7:5] == mMode) begin
                  mSub = nv[4:0];
               end else begin
                  mMode   = 3'b111;
                  mPend   = nv;
                  mSwitch = 1'b1;
                  mEnd    = cyc + GUARD + 1;
               end
            end else begin
               mErr = 1'b1;
            end
         end
         if (mSwitch && cyc == mEnd) begin
            mMode   = mPend[7:5];
            mSub    = mPend[4:0];
            mSwitch = 1'b0;
         end
      end
   end

   always @(negedge ck_1356meg) begin
      if (checkEn) begin
         checkOutput("major_mode", 16'(major_mode), 16'(mMode));
         checkOutput("conf_sub",   16'(conf_sub),   16'(mSub));
         checkOutput("divisor",    16'(divisor),    16'(mDiv));
         checkOutput("switching",  16'(switching),  16'(mSwitch));
         checkOutput("cmd_err",    16'(cmd_err),    16'(mErr));
         if (major_mode == 3'd3) sawMode3 = 1'b1;
         if (switching) sawSwitch = 1'b1;
         if (cmd_err) errSeen++;
      end
   end

   initial begin
      int kind;
      int op;
      int nb;
      logic [15:0] v;

      spck = 1'b0; mosi = 1'b0; ncs = 1'b1; nreset = 1'b1;
      modelReset();
      #2 nreset = 1'b0;
      #1;
      checkOutput("reset_mode",   16'(major_mode), 16'h7);
      checkOutput("reset_sub",    16'(conf_sub),   16'h0);
      checkOutput("reset_div",    16'(divisor),    16'h0);
      checkOutput("reset_switch", 16'(switching),  16'h0);
      checkOutput("reset_err",    16'(cmd_err),    16'h0);
      checkEn = 1;
      tick(3);
      nreset = 1'b1;
      tick(3);

      $display("[TB] mode change from OFF, latency check");
      applyStimulus(16'h1061, 16);
      while (cyc < lastRaise + GUARD + 3) @(negedge ck_1356meg);
      checkOutput("latency_still_off", 16'(major_mode), 16'h7);
      @(negedge ck_1356meg);
      checkOutput("latency_new_mode", 16'(major_mode), 16'h3);
      checkOutput("latency_sub",      16'(conf_sub),   16'h01);
      checkOutput("latency_switch",   16'(switching),  16'h0);
      tick(4);

      $display("[TB] same-mode sub update");
      sawSwitch = 0;
      applyStimulus(16'h1063, 16);
      tick(5);
      checkOutput("samemode_sub",      16'(conf_sub),  16'h03);
      checkOutput("samemode_mode",     16'(major_mode), 16'h3);
      checkOutput("samemode_noswitch", 16'(sawSwitch), 16'h0);

      $display("[TB] retarget during guard");
      applyStimulus(16'h1000, 16);
      tick(GUARD + 10);
      sawMode3 = 0;
      applyStimulus(16'h1061, 16);
      tick(8);
      applyStimulus(16'h10A0, 16);
      tick(GUARD + 10);
      checkOutput("retarget_mode",  16'(major_mode), 16'h5);
      checkOutput("retarget_sub",   16'(conf_sub),   16'h00);
      checkOutput("retarget_no011", 16'(sawMode3),   16'h0);

      $display("[TB] divisor during guard");
      applyStimulus(16'h1022, 16);
      applyStimulus(16'h205F, 16);
      @(negedge ck_1356meg);
      checkOutput("div_before", 16'(divisor), 16'h00);
      @(negedge ck_1356meg);
      checkOutput("div_after",  16'(divisor), 16'h5F);
      tick(GUARD + 10);
      checkOutput("div_mode", 16'(major_mode), 16'h1);
      checkOutput("div_sub",  16'(conf_sub),   16'h02);

      $display("[TB] bad length and unknown opcode");
      errSeen = 0;
      applyStimulus(16'hABCD, 15);
      tick(10);
      checkOutput("short_err_count", 16'(errSeen), 16'd1);
      errSeen = 0;
      applyStimulus(16'h30FF, 16);
      tick(10);
      checkOutput("badop_err_count", 16'(errSeen), 16'd1);
      checkOutput("err_keep_mode", 16'(major_mode), 16'h1);
      checkOutput("err_keep_sub",  16'(conf_sub),   16'h02);
      checkOutput("err_keep_div",  16'(divisor),    16'h5F);

      $display("[TB] async reset mid-guard");
      applyStimulus(16'h1040, 16);
      tick(20);
      checkOutput("pre_reset_switch", 16'(switching), 16'h1);
      nreset = 1'b0;
      modelReset();
      #1;
      checkOutput("midrst_mode",   16'(major_mode), 16'h7);
      checkOutput("midrst_switch", 16'(switching),  16'h0);
      checkOutput("midrst_div",    16'(divisor),    16'h0);
      tick(2);
      nreset = 1'b1;
      tick(3);

      $display("[TB] random traffic");
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         nb = 16;
         if (kind <= 4) begin
            v = {4'h1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
         end else if (kind <= 6) begin
            v = {4'h2, 4'h0, 8'($urandom_range(0, 255))};
         end else if (kind == 7) begin
            op = $urandom_range(0, 13);
            if (op >= 1) op = op + 2;
            v = {4'(op), 12'($urandom_range(0, 4095))};
         end else if (kind == 8) begin
            v = 16'($urandom_range(0, 65535));
            nb = $urandom_range(1, 19);
            if (nb >= 16) nb = nb + 1;
         end else begin
            v = {4'h1, 4'h0, mMode, 5'($urandom_range(0, 31))};
         end
         applyStimulus(v, nb);
         tick($urandom_range(1, 120));
      end
      tick(GUARD + 20);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
